// File: rtl/crc8_pkg.sv
// crc8_pkg: frame geometry, receiver states and the MSB-first CRC-8 step
package crc8_pkg;
    localparam int FRAME_LEN   = 11;
    localparam int CRC_IDX     = 8;
    localparam int PAYLOAD_LEN = 8;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, TRAILER} state_t;
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data, input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ poly : {c[6:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/crc8_frame_rx.sv
// crc8_frame_rx: checks CRC-8 of 11-byte frames, publishes good payload/trailer, counts good/bad frames
module crc8_frame_rx
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter logic [7:0] INITIAL    = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        sof_i,
    output logic [63:0] payload_o,
    output logic [15:0] trailer_o,
    output logic        frame_ok_o,
    output logic        crc_err_o,
    output logic        sync_err_o,
    output logic [3:0]  byte_counter,
    output logic [15:0] good_cnt_o,
    output logic [15:0] bad_cnt_o
);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  crc_q, crc_d;
    logic [63:0] sh_pay_q, sh_pay_d, pay_q, pay_d;
    logic [15:0] sh_tr_q, sh_tr_d, tr_q, tr_d;
    logic [15:0] good_q, good_d, bad_q, bad_d;
    logic        ok_q, ok_d, crc_err_q, crc_err_d, sync_q, sync_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            crc_q     <= '0;
            sh_pay_q  <= '0;
            sh_tr_q   <= '0;
            pay_q     <= '0;
            tr_q      <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            ok_q      <= 1'b0;
            crc_err_q <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            sh_pay_q  <= sh_pay_d;
            sh_tr_q   <= sh_tr_d;
            pay_q     <= pay_d;
            tr_q      <= tr_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            ok_q      <= ok_d;
            crc_err_q <= crc_err_d;
            sync_q    <= sync_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        sh_pay_d  = sh_pay_q;
        sh_tr_d   = sh_tr_q;
        pay_d     = pay_q;
        tr_d      = tr_q;
        good_d    = good_q;
        bad_d     = bad_q;
        ok_d      = 1'b0;
        crc_err_d = 1'b0;
        sync_d    = 1'b0;
        // sof always restarts a frame; outside IDLE it also aborts the current one
        if (valid_i && sof_i) begin
            sync_d            = state_q != IDLE;
            bad_d             = (sync_d && !(&bad_q)) ? bad_q + 16'd1 : bad_q;
            crc_d             = crc8_next(INITIAL, data_i, POLYNOMIAL);
            sh_pay_d[63:56]   = data_i;
            cnt_d             = 4'd1;
            state_d           = PAYLOAD;
        end else if (valid_i) begin
            case (state_q)
                PAYLOAD: begin
                    crc_d = crc8_next(crc_q, data_i, POLYNOMIAL);
                    sh_pay_d[8 * (PAYLOAD_LEN - 1 - int'(cnt_q)) +: 8] = data_i;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = cnt_q == 4'(PAYLOAD_LEN - 1) ? CHECK : PAYLOAD;
                end
                CHECK: begin
                    crc_err_d = data_i != crc_q;
                    bad_d     = (crc_err_d && !(&bad_q)) ? bad_q + 16'd1 : bad_q;
                    cnt_d     = crc_err_d ? 4'd0 : 4'(CRC_IDX + 1);
                    state_d   = crc_err_d ? IDLE : TRAILER;
                end
                TRAILER: begin
                    if (cnt_q == 4'(FRAME_LEN - 1)) begin
                        pay_d   = sh_pay_q;
                        tr_d    = {sh_tr_q[15:8], data_i};
                        sh_tr_d = {sh_tr_q[15:8], data_i};
                        ok_d    = 1'b1;
                        good_d  = &good_q ? good_q : good_q + 16'd1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        sh_tr_d[15:8] = data_i;
                        cnt_d         = cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign payload_o    = pay_q;
    assign trailer_o    = tr_q;
    assign frame_ok_o   = ok_q;
    assign crc_err_o    = crc_err_q;
    assign sync_err_o   = sync_q;
    assign byte_counter = cnt_q;
    assign good_cnt_o   = good_q;
    assign bad_cnt_o    = bad_q;
endmodule

// File: doc/crc8_frame_rx.md
# crc8_frame_rx

Receive-side counterpart of the CRC-8 frame generator. It accepts the 11-byte transmit frame one byte per valid cycle:
- bytes 0–7 are payload;
- byte 8 is CRC-8 (poly 0x07, init 0xFF) over bytes 0–7;
- bytes 9–10 are trailer.

The block checks the CRC, publishes the payload and trailer of each good frame, and keeps good/bad frame statistics. It sits between the byte deserializer and the trigger-decode logic.

## Interface
- POLYNOMIAL, 8'h07, CRC-8 generator polynomial (MSB-first, non-reflected, no final XOR)
- INITIAL, 8'hFF, CRC register value at byte 0
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- data_i  input  8  received byte
- valid_i  input  1  data_i holds a byte this cycle
- sof_i  input  1  qualifies data_i as byte 0 of a frame (ignored when valid_i=0)
- payload_o  output  64  payload of the last good frame, byte 0 in [63:56]; reset 0
- trailer_o  output  16  bytes 9,10 of the last good frame, byte 9 in [15:8]; reset 0
- frame_ok_o  output  1  one-cycle pulse: good frame completed; reset 0
- crc_err_o  output  1  one-cycle pulse: CRC byte mismatch; reset 0
- sync_err_o  output  1  one-cycle pulse: frame aborted by early sof_i; reset 0
- byte_counter  output  4  index of the next expected byte (0–10); reset 0
- good_cnt_o  output  16  saturating good-frame count; reset 0
- bad_cnt_o  output  16  saturating CRC-error plus sync-error count; reset 0

## Operation
- States:
  - IDLE: waiting for valid_i & sof_i.
  - PAYLOAD: accepting bytes 1–7.
  - CHECK: expecting byte 8.
  - TRAILER: accepting bytes 9–10.
- IDLE:
  - A byte is accepted only when valid_i & sof_i.
  - On acceptance: CRC <= crc8_next(INITIAL, data_i); byte 0 is stored in the shadow payload; go to PAYLOAD; byte_counter = 1.
  - valid_i without sof_i is dropped silently.
- PAYLOAD: each valid byte updates CRC, is stored at shadow index byte_counter, and increments byte_counter. After byte 7 is accepted, go to CHECK.
- CHECK:
  - Match (data_i == CRC): go to TRAILER.
  - Mismatch: pulse crc_err_o, increment bad_cnt_o, go to IDLE, byte_counter = 0.
- TRAILER:
  - Bytes 9 and 10 go into the shadow trailer.
  - On byte 10: copy shadow payload to payload_o and shadow trailer to trailer_o, pulse frame_ok_o, increment good_cnt_o, go to IDLE, byte_counter = 0.
- Early sof_i (valid_i & sof_i in PAYLOAD, CHECK or TRAILER):
  - Abort the frame, pulse sync_err_o, increment bad_cnt_o.
  - Treat the same byte as byte 0 of a new frame: byte_counter = 1, CRC restarted.
- sof_i on the CRC byte: treated as early sof_i; no CRC compare, no crc_err_o.
- valid_i low: no state or counter change; gaps of any length are tolerated mid-frame.
- payload_o and trailer_o change only on frame_ok. They hold the previous good frame through bad or aborted frames.
- Counters saturate at 16'hFFFF.
- Mid-operation reset: all outputs and shadows return to 0, state goes to IDLE; a partial frame is discarded with no pulse.

## Timing
- A byte is accepted on the clk edge where valid_i=1.
- byte_counter updates on that same edge.
- frame_ok_o, crc_err_o and sync_err_o are registered. They go high the cycle after the accepting edge, for exactly one cycle.
- payload_o, trailer_o and the counters update on the same edge that raises the pulse.
- Back-to-back frames with valid_i always high are supported with zero idle cycles: byte 0 of the next frame may arrive the cycle after byte 10.
- The CRC compare uses the registered CRC of bytes 0–7; no extra pipeline stage.

## Structure
- Package crc8_pkg holds:
  - FRAME_LEN = 11, CRC_IDX = 8, PAYLOAD_LEN = 8;
  - the state enum;
  - function crc8_next(crc, byte, poly): 8 shift/XOR steps, MSB first.
- The transmitter adopts the same package.
- No sub-module: the CRC is a single register driven by crc8_next.

## Test plan
- Good frame: sof on FF, then 00×6, 01, CRC 07, trailer A5 5A → frame_ok_o pulse; payload_o = 64'hFF00000000000001; trailer_o = 16'hA55A; good_cnt_o = 1.
- Corrupt CRC: same payload with CRC byte 06 → crc_err_o pulse the cycle after byte 8; bad_cnt_o = 1; payload_o unchanged; bytes 9–10 dropped (no sof).
- Early sof: sof_i reasserted at byte 5 → sync_err_o pulse; byte_counter = 1; the following 10 correct bytes complete as a good frame.
- Gaps and back-to-back: random valid_i gaps within a frame, then two consecutive good frames with valid_i held high → two frame_ok_o pulses exactly 11 cycles apart.
- Reset mid-frame: reset low for 1 cycle at byte 6 → all outputs 0; no pulse; the next frame is received correctly.
- Saturation: force 65536 bad frames → bad_cnt_o holds FFFF.
